seg7_scan_display: RTL and testbench

//  Drives the board's 8-digit multiplexed 7-segment display from the two 16-bit debug

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/hex_to_seg7.sv | 33 +++
 rtl/seg7_scan_display.sv | 115 +++++++++++
 tb/tb_seg7_scan_display.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit scanned 7-segment display: scan FSM states,
// active-low segment patterns {g,f,e,d,c,b,a} and the all-off constants.
package seg7_pkg;

   typedef enum logic {
      ST_ON    = 1'b0,
      ST_BLANK = 1'b1
   } state_t;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b0000011;
   localparam logic [6:0] SEG_C   = 7'b1000110;
   localparam logic [6:0] SEG_D   = 7'b0100001;
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_F   = 7'b0001110;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [7:0] ANODE_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      // NOTE: default assignment first so no path through the block can infer a latch.
      o_seg = SEG_OFF;
      case (i_hex)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Scans y (digits 7..4) and x (digits 3..0) onto an 8-digit multiplexed display with a
// blanking gap between digits. Define SEG7_LZB_EN for per-group leading-zero blanking.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic        Clk,
   input  logic        rst,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        load,
   output logic [6:0]  out7,
   output logic [7:0]  en_out
);

   localparam int PW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLANK_CYCLES + 1);

   logic [15:0]   r_x_q;
   logic [15:0]   r_y_q;
   state_t        r_state;
   logic [PW-1:0] r_pre;
   logic [BW-1:0] r_blank;
   logic [2:0]    r_idx;
   logic          r_first;

   logic [15:0]   w_group;
   logic [3:0]    w_nibble;
   logic [6:0]    w_seg;
   logic          w_lz_blank;

   // NOTE: sequential state always uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         r_x_q <= '0;
         r_y_q <= '0;
      end else if (load) begin
         r_x_q <= x;
         r_y_q <= y;
      end
   end

   // The first BLANK after reset leads into digit 0, so it must not advance idx.
   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_BLANK;
         r_pre   <= '0;
         r_blank <= '0;
         r_idx   <= '0;
         r_first <= 1'b1;
      end else begin
         case (r_state)
            ST_ON: begin
               if (r_pre == PW'(REFRESH_DIV - 1)) begin
                  r_pre   <= '0;
                  r_state <= ST_BLANK;
               end else begin
                  r_pre <= r_pre + 1'b1;
               end
            end
            ST_BLANK: begin
               if (r_blank == BW'(BLANK_CYCLES - 1)) begin
                  r_blank <= '0;
                  r_state <= ST_ON;
                  r_first <= 1'b0;
                  if (!r_first) r_idx <= r_idx + 1'b1;
               end else begin
                  r_blank <= r_blank + 1'b1;
               end
            end
            default: r_state <= ST_BLANK;
         endcase
      end
   end

   assign w_group  = r_idx[2] ? r_y_q : r_x_q;
   assign w_nibble = w_group[{r_idx[1:0], 2'b00} +: 4];

   hex_to_seg7 u_dec (
      .i_hex (w_nibble),
      .o_seg (w_seg)
   );

`ifdef SEG7_LZB_EN
   // Digit k of a group is blank when it and every higher nibble of the group are zero.
   always_comb begin
      w_lz_blank = 1'b0;
      case (r_idx[1:0])
         2'd1:    w_lz_blank = (w_group[15:4]  == 12'h000);
         2'd2:    w_lz_blank = (w_group[15:8]  == 8'h00);
         2'd3:    w_lz_blank = (w_group[15:12] == 4'h0);
         default: w_lz_blank = 1'b0;
      endcase
   end
`else
   assign w_lz_blank = 1'b0;
`endif

   always_ff @(posedge Clk or posedge rst) begin
      if (rst) begin
         out7   <= SEG_OFF;
         en_out <= ANODE_OFF;
      end else if (r_state == ST_ON && !w_lz_blank) begin
         out7   <= w_seg;
         en_out <= ~(8'b1 << r_idx);
      end else begin
         out7   <= SEG_OFF;
         en_out <= ANODE_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a driver pushes the expected outputs of each
// upcoming edge from a timing/arithmetic reference model; a monitor pops and compares.
module tb_seg7_scan_display;

   localparam int RD    = 4;
   localparam int BC    = 1;
   localparam int SLOT  = RD + BC;
   localparam int FRAME = 8 * SLOT;

   logic        Clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic [6:0]  out7;
   logic [7:0]  en_out;

   seg7_scan_display #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
      .Clk    (Clk),
      .rst    (rst),
      .x      (x),
      .y      (y),
      .load   (load),
      .out7   (out7),
      .en_out (en_out)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [7:0] en;
      logic [6:0] seg;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_edge  = 0;
   logic [15:0] m_x = '0;
   logic [15:0] m_y = '0;

   function automatic logic [6:0] hex_seg(input logic [3:0] h);
      logic [6:0] tab [16];
      tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return tab[h];
   endfunction

   // Expected outputs after the n-th rising edge since reset release.
   function automatic exp_t model(input int n, input logic [15:0] mx, input logic [15:0] my);
      exp_t        e;
      int          m, d, k;
      logic [15:0] g;
      logic        blank;
      e.en  = 8'hFF;
      e.seg = 7'h7F;
      if (n >= BC + 1) begin
         m = (n - BC - 1) % FRAME;
         d = m / SLOT;
         if ((m % SLOT) < RD) begin
            g     = (d < 4) ? mx : my;
            k     = d % 4;
            blank = 1'b0;
`ifdef SEG7_LZB_EN
            if (k > 0 && (g >> (4 * k)) == 16'h0) blank = 1'b1;
`endif
            if (!blank) begin
               e.en  = ~(8'd1 << d);
               e.seg = hex_seg(4'(g >> (4 * k)));
            end
         end
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got en_out=%h out7=%b, expected en_out=%h out7=%b",
                  name, $time, act[14:7], act[6:0], exp[14:7], exp[6:0]);
      end
   endtask

   task automatic step(input logic r, input logic ld, input logic [15:0] nx, input logic [15:0] ny);
      logic was;
      @(negedge Clk);
      was  = rst;
      rst  = r;
      load = ld;
      x    = nx;
      y    = ny;
      if (r && !was) begin
         #1;
         check("async_reset", {en_out, out7}, {8'hFF, 7'h7F});
      end
      if (r) begin
         n_edge = 0;
         q.push_back('{8'hFF, 7'h7F});
         m_x = '0;
         m_y = '0;
      end else begin
         n_edge++;
         q.push_back(model(n_edge, m_x, m_y));
         if (ld) begin
            m_x = nx;
            m_y = ny;
         end
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, x, y);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("scan", {en_out, out7}, e);
         end
      end
   end

   initial begin : driver
      int m;
      bit found;
      repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0);

      // scan order and decode of 1234 / 5678
      step(1'b0, 1'b1, 16'h1234, 16'h5678);
      idle(FRAME + 10);

      // mid-scan reset, then hex letters
      step(1'b1, 1'b0, 16'h1234, 16'h5678);
      step(1'b1, 1'b0, 16'h1234, 16'h5678);
      step(1'b0, 1'b1, 16'hFA10, 16'h0C3D);
      idle(FRAME + 5);

      // hold while load is low, then reload while digit 3 is lit
      step(1'b0, 1'b1, 16'h1234, 16'h9876);
      step(1'b0, 1'b0, 16'hBEEF, 16'h9876);
      idle(FRAME);
      found = 1'b0;
      for (int i = 0; i < FRAME && !found; i++) begin
         m = (n_edge + 1 - BC - 1) % FRAME;
         if (m / SLOT == 3 && m % SLOT == 1) found = 1'b1;
         else idle(1);
      end
      n_tests++;
      if (!found) begin
         n_fail++;
         $display("FAIL digit3_search: slot for digit 3 not reached, expected within %0d cycles", FRAME);
      end
      step(1'b0, 1'b1, 16'hBEEF, 16'h9876);
      idle(FRAME + 5);

      // zeros: leading-zero blanking when enabled, all zeros shown otherwise
      step(1'b0, 1'b1, 16'h0005, 16'h0000);
      idle(FRAME + 5);
      step(1'b0, 1'b1, 16'h0700, 16'h0030);
      idle(FRAME + 5);

      // randomized loads
      for (int i = 0; i < 240; i++)
         step(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 16'($urandom));

      repeat (3) @(posedge Clk);
      #2;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected items left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
